dm_arbiter: RTL and testbench

- Controller and arbiter in front of the 1024x32 data memory. It shares the memory between the CPU load/store port and a DMA/loader port.
- CPU port supports word and byte accesses; DMA port supports word accesses only.
- Byte stores use an internal read-modify-write sequence. Byte loads are sign- or zero-extended.
- Drives a plain memory macro that has a synchronous read and a single write-enable.

---
 rtl/dm_arb_pkg.sv | 22 ++
 rtl/dm_byte_lane.sv | 23 ++
 rtl/dm_arbiter.sv | 155 +++++++++++++++
 tb/tb_dm_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the FSM encoding, grant ids, lane width and per-operation latencies.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD    = 2'd1,
    ST_RDATA = 2'd2,
    ST_WR    = 2'd3
  } state_t;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_DMA = 1'b1;

  localparam int LANE_W = 8;

  // Edges from the request-sampling edge to the ready pulse.
  localparam int LAT_WORD_ST = 1;
  localparam int LAT_LOAD    = 2;
  localparam int LAT_BYTE_ST = 3;

endpackage

// File: rtl/dm_byte_lane.sv
// Combinational byte lane helper: extracts a lane with sign/zero extension and
// merges a byte into a word; zero latency, no flow control.
module dm_byte_lane
  import dm_arb_pkg::*;
(
  input  logic [31:0]       word_i,
  input  logic [1:0]        lane_i,
  input  logic              sext_i,
  input  logic [LANE_W-1:0] byte_i,
  output logic [31:0]       ext_o,
  output logic [31:0]       merged_o
);

  logic [LANE_W-1:0] sel_byte;

  always_comb begin
    sel_byte = word_i[lane_i*LANE_W +: LANE_W];
    ext_o    = {{(32-LANE_W){sext_i & sel_byte[LANE_W-1]}}, sel_byte};
    merged_o = word_i;
    merged_o[lane_i*LANE_W +: LANE_W] = byte_i;
  end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin CPU/DMA arbiter and controller for a sync-read data memory macro.
// Ready after 1 (word store), 2 (load) or 3 (byte store) edges; requesters hold req until ready.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int WORDS  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_word,
  input  logic              cpu_sext,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic [31:0]       dma_rdata,
  output logic              dma_ready,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  localparam logic [ADDR_W-3:0] WADDR_MASK = (ADDR_W-2)'(WORDS-1);

  state_t            state_q;
  logic              gnt_q, last_gnt_q;
  logic              we_q, word_q, sext_q;
  logic [1:0]        lane_q;
  logic [LANE_W-1:0] byte_q;
  logic [ADDR_W-3:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [31:0]       cpu_rdata_q, dma_rdata_q;
  logic              cpu_ready_q, dma_ready_q;

  logic              req_any_d, gnt_d, we_d, word_d, sext_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_d;
  logic [31:0]       lane_ext, lane_merged, load_dat;

  // The CPU only loses a tie when it was the last one served.
  always_comb begin
    req_any_d = cpu_req | dma_req;
    gnt_d     = (cpu_req && (!dma_req || last_gnt_q == GNT_DMA)) ? GNT_CPU : GNT_DMA;
    if (gnt_d == GNT_CPU) begin
      we_d    = cpu_we;
      word_d  = cpu_word;
      sext_d  = cpu_sext;
      addr_d  = cpu_addr;
      wdata_d = cpu_wdata;
    end else begin
      we_d    = dma_we;
      word_d  = 1'b1;
      sext_d  = 1'b0;
      addr_d  = dma_addr;
      wdata_d = dma_wdata;
    end
  end

  dm_byte_lane u_lane (
    .word_i   (mem_rdata),
    .lane_i   (lane_q),
    .sext_i   (sext_q),
    .byte_i   (byte_q),
    .ext_o    (lane_ext),
    .merged_o (lane_merged)
  );

  assign load_dat = word_q ? mem_rdata : lane_ext;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= GNT_CPU;
      last_gnt_q  <= GNT_DMA;
      we_q        <= 1'b0;
      word_q      <= 1'b0;
      sext_q      <= 1'b0;
      lane_q      <= '0;
      byte_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
    end else begin
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (req_any_d) begin
            gnt_q      <= gnt_d;
            last_gnt_q <= gnt_d;
            we_q       <= we_d;
            word_q     <= word_d;
            sext_q     <= sext_d;
            lane_q     <= addr_d[1:0];
            byte_q     <= wdata_d[LANE_W-1:0];
            mem_addr_q <= addr_d[ADDR_W-1:2] & WADDR_MASK;
            if (we_d && word_d) begin
              mem_wdata_q <= wdata_d;
              state_q     <= ST_WR;
            end else begin
              state_q     <= ST_RD;
            end
          end
        end
        ST_RD: state_q <= ST_RDATA;
        ST_RDATA: begin
          if (we_q) begin
            mem_wdata_q <= lane_merged;
            state_q     <= ST_WR;
          end else begin
            if (gnt_q == GNT_CPU) begin
              cpu_rdata_q <= load_dat;
              cpu_ready_q <= 1'b1;
            end else begin
              dma_rdata_q <= load_dat;
              dma_ready_q <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
        end
        ST_WR: begin
          if (gnt_q == GNT_CPU) cpu_ready_q <= 1'b1;
          else                  dma_ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Gating with rst_n keeps a reset that lands in WR from committing the write.
  assign mem_we    = (state_q == ST_WR) & rst_n;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign dma_rdata = dma_rdata_q;
  assign dma_ready = dma_ready_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural 1024x32 sync-read memory.
module tb_dm_arbiter;
  import dm_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_word, cpu_sext;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic        dma_req, dma_we;
  logic [11:0] dma_addr;
  logic [31:0] dma_wdata, dma_rdata;
  logic        dma_ready;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata, mem_rdata;
  logic        busy;

  logic [31:0] mem [0:1023];
  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [31:0] bd_dat;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.ADDR_W(12), .WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_word(cpu_word), .cpu_sext(cpu_sext),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ready(dma_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always @(posedge clk) begin
    if (mem_we)     mem[mem_addr] <= mem_wdata;
    else if (bd_we) mem[bd_addr]  <= bd_dat;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic backdoor(input logic [9:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_dat = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic cpu_op(input logic we, input logic word, input logic sext,
                        input logic [11:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd,
                        output int we_cyc, output logic [9:0] we_addr);
    cpu_req = 1'b1; cpu_we = we; cpu_word = word; cpu_sext = sext;
    cpu_addr = addr; cpu_wdata = wd;
    we_cyc = 0; we_addr = '0; lat = 0;
    tick();
    if (mem_we) begin we_cyc++; we_addr = mem_addr; end
    while (!cpu_ready && lat < 20) begin
      tick();
      lat++;
      if (mem_we) begin we_cyc++; we_addr = mem_addr; end
    end
    rd = cpu_rdata;
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic dma_op(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd);
    dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wd;
    lat = 0;
    tick();
    while (!dma_ready && lat < 20) begin
      tick();
      lat++;
    end
    rd = dma_rdata;
    dma_req = 1'b0;
    tick();
  endtask

  initial begin
    int          lat, wec, n, seen_cpu, seen_dma, got;
    logic [31:0] rd;
    logic [9:0]  wa;
    logic [7:0]  seq;

    rst_n = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_dat = '0;
    cpu_req = 0; cpu_we = 0; cpu_word = 0; cpu_sext = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;

    backdoor(10'h008, 32'h11223344);
    backdoor(10'h00C, 32'h80FF017F);
    backdoor(10'h010, 32'h00000000);
    backdoor(10'h0FF, 32'hCAFEF00D);

    chk("rst cpu_ready", {31'b0, cpu_ready}, 32'h0);
    chk("rst dma_ready", {31'b0, dma_ready}, 32'h0);
    chk("rst cpu_rdata", cpu_rdata, 32'h0);
    chk("rst dma_rdata", dma_rdata, 32'h0);
    chk("rst mem_addr", {22'b0, mem_addr}, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst busy", {31'b0, busy}, 32'h0);
    chk("rst mem_we", {31'b0, mem_we}, 32'h0);

    rst_n = 1'b1;
    tick();

    // Word store then word load.
    cpu_op(1'b1, 1'b1, 1'b0, 12'h010, 32'hDEADBEEF, lat, rd, wec, wa);
    chk("wst latency", 32'(lat), 32'(LAT_WORD_ST));
    chk("wst we cycles", 32'(wec), 32'd1);
    chk("wst mem_addr", {22'b0, wa}, 32'h004);
    chk("wst mem word", mem[4], 32'hDEADBEEF);
    cpu_op(1'b0, 1'b1, 1'b0, 12'h010, 32'h0, lat, rd, wec, wa);
    chk("wld latency", 32'(lat), 32'(LAT_LOAD));
    chk("wld data", rd, 32'hDEADBEEF);
    chk("wld no write", 32'(wec), 32'd0);

    // Byte store merges lane 2 only; upper wdata bits must be ignored.
    cpu_op(1'b1, 1'b0, 1'b0, 12'h022, 32'hFFFFFFAA, lat, rd, wec, wa);
    chk("bst latency", 32'(lat), 32'(LAT_BYTE_ST));
    chk("bst we cycles", 32'(wec), 32'd1);
    chk("bst mem_addr", {22'b0, wa}, 32'h008);
    chk("bst mem word", mem[8], 32'h11AA3344);

    // Byte loads with sign and zero extension.
    cpu_op(1'b0, 1'b0, 1'b1, 12'h030, 32'h0, lat, rd, wec, wa);
    chk("bld 030 sext", rd, 32'h0000007F);
    chk("bld latency", 32'(lat), 32'(LAT_LOAD));
    cpu_op(1'b0, 1'b0, 1'b1, 12'h031, 32'h0, lat, rd, wec, wa);
    chk("bld 031 sext", rd, 32'h00000001);
    cpu_op(1'b0, 1'b0, 1'b1, 12'h033, 32'h0, lat, rd, wec, wa);
    chk("bld 033 sext", rd, 32'hFFFFFF80);
    cpu_op(1'b0, 1'b0, 1'b0, 12'h033, 32'h0, lat, rd, wec, wa);
    chk("bld 033 zext", rd, 32'h00000080);

    // DMA word write ignores addr[1:0]; DMA word read back.
    dma_op(1'b1, 12'h105, 32'h12345678, lat, rd);
    chk("dma wr latency", 32'(lat), 32'(LAT_WORD_ST));
    chk("dma wr mem word", mem[10'h041], 32'h12345678);
    dma_op(1'b0, 12'h106, 32'h0, lat, rd);
    chk("dma rd latency", 32'(lat), 32'(LAT_LOAD));
    chk("dma rd data", rd, 32'h12345678);

    // DMA read arriving while a CPU load is in flight.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_word = 1'b1; cpu_addr = 12'h010;
    tick();
    chk("inflight busy E0", {31'b0, busy}, 32'h1);
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 12'h3FC;
    n = 0; seen_cpu = 0; seen_dma = 0;
    while (seen_dma == 0 && n < 20) begin
      tick();
      n++;
      if (n == 1) chk("inflight busy E1", {31'b0, busy}, 32'h1);
      if (cpu_ready) begin
        seen_cpu = 1;
        chk("inflight cpu data", cpu_rdata, 32'hDEADBEEF);
        chk("inflight dma quiet", {31'b0, dma_ready}, 32'h0);
        cpu_req = 1'b0;
      end
      if (dma_ready) begin
        seen_dma = 1;
        chk("dma after cpu", 32'(seen_cpu), 32'd1);
        chk("dma rd 3FC", dma_rdata, 32'hCAFEF00D);
        chk("cpu_rdata zero", cpu_rdata, 32'h0);
        chk("dma ready edge", 32'(n), 32'd5);
        dma_req = 1'b0;
      end
    end
    chk("dma ready seen", 32'(seen_dma), 32'd1);
    tick();

    // Reset landing in the WR cycle of a byte store.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_word = 1'b0; cpu_addr = 12'h040; cpu_wdata = 32'h00000055;
    tick(); tick(); tick();
    chk("pre-reset mem_we", {31'b0, mem_we}, 32'h1);
    rst_n = 1'b0; cpu_req = 1'b0;
    #1;
    chk("reset gates mem_we", {31'b0, mem_we}, 32'h0);
    tick();
    chk("reset busy", {31'b0, busy}, 32'h0);
    chk("reset no ready", {31'b0, cpu_ready}, 32'h0);
    chk("reset word kept", mem[10'h010], 32'h0);
    chk("reset mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    tick();

    // Both held continuously from reset: CPU first, then strict alternation.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_word = 1'b1; cpu_addr = 12'h010;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 12'h3FC;
    seq = '0; got = 0; n = 0;
    while (got < 8 && n < 60) begin
      tick();
      n++;
      if (cpu_ready || dma_ready) begin
        chk("rr single ready", {31'b0, cpu_ready & dma_ready}, 32'h0);
        seq[got] = dma_ready;
        got++;
        if (got == 8) begin cpu_req = 1'b0; dma_req = 1'b0; end
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    chk("rr count", 32'(got), 32'd8);
    chk("rr order", {24'b0, seq}, 32'h000000AA);
    repeat (4) tick();
    chk("end idle", {31'b0, busy}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
